// File: rtl/multi_cycle_ctrl.sv
// Control FSM for the multi-cycle CPU: sequences IF/ID/EXE/MEM/WB, decodes the latched
// opcode into datapath controls and counts retired instructions.
module multi_cycle_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             PCWre,
    output logic             IRWre,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic [2:0]       ALUCtr,
    output logic             ExtSel,
    output logic             RegDst,
    output logic             RegWre,
    output logic             WrRegDSrc,
    output logic             mRD,
    output logic             mWR,
    output logic [1:0]       PCSrc,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        StIf   = 3'b000,
        StId   = 3'b001,
        StExe  = 3'b010,
        StMem  = 3'b011,
        StWb   = 3'b100,
        StHalt = 3'b111
    } stateT;

    typedef enum logic [3:0] {
        ClsR, ClsI, ClsLw, ClsSw, ClsBeq, ClsBne, ClsJ, ClsHalt, ClsNop
    } clsT;

    stateT            stateQ;
    logic [5:0]       opQ;
    logic [CNT_W-1:0] retiredQ;

    clsT        cls;
    logic [2:0] aluOp;
    logic       srcA;
    logic       srcB;
    logic       extSign;

    always_comb begin
        cls     = ClsNop;
        aluOp   = 3'b000;
        srcA    = 1'b0;
        srcB    = 1'b0;
        extSign = 1'b0;
        case (opQ)
            6'b000000: cls = ClsR;
            6'b000001: begin cls = ClsR; aluOp = 3'b001; end
            6'b000010: begin cls = ClsI; srcB = 1'b1; extSign = 1'b1; end
            6'b010000: begin cls = ClsR; aluOp = 3'b010; end
            6'b010001: begin cls = ClsI; aluOp = 3'b010; srcB = 1'b1; end
            6'b010010: begin cls = ClsR; aluOp = 3'b011; end
            6'b010011: begin cls = ClsI; aluOp = 3'b011; srcB = 1'b1; end
            6'b011000: begin cls = ClsR; aluOp = 3'b100; srcA = 1'b1; end
            6'b011001: begin cls = ClsR; aluOp = 3'b111; end
            6'b100110: begin cls = ClsR; aluOp = 3'b101; end
            6'b100111: begin cls = ClsI; aluOp = 3'b101; srcB = 1'b1; extSign = 1'b1; end
            6'b110000: begin cls = ClsSw; srcB = 1'b1; extSign = 1'b1; end
            6'b110001: begin cls = ClsLw; srcB = 1'b1; extSign = 1'b1; end
            6'b110100: begin cls = ClsBeq; aluOp = 3'b001; end
            6'b110101: begin cls = ClsBne; aluOp = 3'b001; end
            6'b111000: cls = ClsJ;
            6'b111111: cls = ClsHalt;
            default:   cls = ClsNop;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= StIf;
            opQ      <= 6'b000000;
            retiredQ <= '0;
        end else if (en) begin
            // PCWre already carries en, so this counts each instruction exactly once
            if (PCWre) begin
                retiredQ <= retiredQ + CNT_W'(1);
            end
            unique case (stateQ)
                StIf: begin
                    opQ    <= opcode;
                    stateQ <= StId;
                end
                StId: begin
                    case (cls)
                        ClsJ, ClsNop: stateQ <= StIf;
                        ClsHalt:      stateQ <= StHalt;
                        default:      stateQ <= StExe;
                    endcase
                end
                StExe: begin
                    case (cls)
                        ClsR, ClsI:   stateQ <= StWb;
                        ClsLw, ClsSw: stateQ <= StMem;
                        default:      stateQ <= StIf;
                    endcase
                end
                StMem:   stateQ <= (cls == ClsLw) ? StWb : StIf;
                StWb:    stateQ <= StIf;
                StHalt:  stateQ <= StHalt;
                default: stateQ <= StIf;
            endcase
        end
    end

    logic inAlu;
    logic inExec;
    logic isBranch;
    logic pcDone;

    always_comb begin
        inAlu    = (stateQ == StExe) || (stateQ == StMem);
        inExec   = inAlu || (stateQ == StWb);
        isBranch = (cls == ClsBeq) || (cls == ClsBne);
        pcDone   = (stateQ == StWb)
                || ((stateQ == StMem) && (cls == ClsSw))
                || ((stateQ == StExe) && isBranch)
                || ((stateQ == StId) && ((cls == ClsJ) || (cls == ClsNop)));

        ALUSrcA   = inAlu && srcA;
        ALUSrcB   = inAlu && srcB;
        ALUCtr    = inAlu ? aluOp : 3'b000;
        ExtSel    = inAlu && extSign;
        RegDst    = inExec && (cls == ClsR);
        WrRegDSrc = inExec && (cls == ClsLw);
        // Side-effecting enables drop while frozen so a held state never repeats a write
        RegWre    = en && (stateQ == StWb);
        mRD       = (stateQ == StMem) && (cls == ClsLw);
        mWR       = en && (stateQ == StMem) && (cls == ClsSw);
        PCWre     = en && pcDone;
        IRWre     = (stateQ == StIf);

        PCSrc = 2'b00;
        if ((stateQ == StExe)
            && (((cls == ClsBeq) && zero) || ((cls == ClsBne) && !zero))) begin
            PCSrc = 2'b01;
        end else if ((stateQ == StId) && (cls == ClsJ)) begin
            PCSrc = 2'b10;
        end

        state   = stateQ;
        halted  = (stateQ == StHalt);
        retired = retiredQ;
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: table of per-cycle vectors plus hand-written
// sequences for enable hold, NOP/J/HALT and mid-instruction reset.
module tb_multi_cycle_ctrl;

    localparam int CNT_W = 16;

    localparam logic [5:0] OpAdd   = 6'b000000;
    localparam logic [5:0] OpAddiu = 6'b000010;
    localparam logic [5:0] OpOri   = 6'b010011;
    localparam logic [5:0] OpSll   = 6'b011000;
    localparam logic [5:0] OpSw    = 6'b110000;
    localparam logic [5:0] OpLw    = 6'b110001;
    localparam logic [5:0] OpBeq   = 6'b110100;
    localparam logic [5:0] OpBne   = 6'b110101;
    localparam logic [5:0] OpJ     = 6'b111000;
    localparam logic [5:0] OpHalt  = 6'b111111;
    localparam logic [5:0] OpNop   = 6'b101010;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             zero = 1'b0;
    logic [5:0]       opcode = 6'b0;
    logic             PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegDst, RegWre;
    logic             WrRegDSrc, mRD, mWR, halted;
    logic [2:0]       ALUCtr, state;
    logic [1:0]       PCSrc;
    logic [CNT_W-1:0] retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUCtr(ALUCtr), .ExtSel(ExtSel), .RegDst(RegDst), .RegWre(RegWre),
        .WrRegDSrc(WrRegDSrc), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc),
        .state(state), .halted(halted), .retired(retired)
    );

    logic [18:0] actCtl;
    assign actCtl = {state, PCWre, IRWre, ALUSrcA, ALUSrcB, ALUCtr, ExtSel, RegDst,
                     RegWre, WrRegDSrc, mRD, mWR, PCSrc, halted};

    typedef struct {
        logic        en;
        logic [5:0]  op;
        logic        zero;
        logic [18:0] ctl;
        logic [15:0] ret;
    } vecT;

    vecT vecs[$];

    // Field order: st pcw irw sa sb ctr ext rd rw wds mrd mwr pcs hlt ret
    function automatic void add(input bit e, input logic [5:0] op, input bit z,
                                input logic [2:0] st, input bit pcw, input bit irw,
                                input bit sa, input bit sb, input logic [2:0] ctr,
                                input bit ext, input bit rd, input bit rw, input bit wds,
                                input bit mrd, input bit mwr, input logic [1:0] pcs,
                                input bit hlt, input int ret);
        vecT v;
        v.en   = e;
        v.op   = op;
        v.zero = z;
        v.ctl  = {st, pcw, irw, sa, sb, ctr, ext, rd, rw, wds, mrd, mwr, pcs, hlt};
        v.ret  = 16'(ret);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setIn(input bit e, input logic [5:0] op, input bit z);
        en     = e;
        opcode = op;
        zero   = z;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ADD
        add(1, OpAdd, 0,   3'd0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        add(1, OpAdd, 0,   3'd1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        add(1, OpAdd, 0,   3'd2, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0);
        add(1, OpAdd, 0,   3'd4, 1, 0, 0, 0, 3'b000, 0, 1, 1, 0, 0, 0, 2'b00, 0, 0);
        // ADDIU
        add(1, OpAddiu, 0, 3'd0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        add(1, OpAddiu, 0, 3'd1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        add(1, OpAddiu, 0, 3'd2, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0, 0, 2'b00, 0, 1);
        add(1, OpAddiu, 0, 3'd4, 1, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 2'b00, 0, 1);
        // LW
        add(1, OpLw, 0,    3'd0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2);
        add(1, OpLw, 0,    3'd1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2);
        add(1, OpLw, 0,    3'd2, 0, 0, 0, 1, 3'b000, 1, 0, 0, 1, 0, 0, 2'b00, 0, 2);
        add(1, OpLw, 0,    3'd3, 0, 0, 0, 1, 3'b000, 1, 0, 0, 1, 1, 0, 2'b00, 0, 2);
        add(1, OpLw, 0,    3'd4, 1, 0, 0, 0, 3'b000, 0, 0, 1, 1, 0, 0, 2'b00, 0, 2);
        // SW
        add(1, OpSw, 0,    3'd0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3);
        add(1, OpSw, 0,    3'd1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3);
        add(1, OpSw, 0,    3'd2, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0, 0, 2'b00, 0, 3);
        add(1, OpSw, 0,    3'd3, 1, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0, 1, 2'b00, 0, 3);
        // BEQ taken, BEQ not taken, BNE taken
        add(1, OpBeq, 1,   3'd0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4);
        add(1, OpBeq, 1,   3'd1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4);
        add(1, OpBeq, 1,   3'd2, 1, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 2'b01, 0, 4);
        add(1, OpBeq, 0,   3'd0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 5);
        add(1, OpBeq, 0,   3'd1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 5);
        add(1, OpBeq, 0,   3'd2, 1, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 2'b00, 0, 5);
        add(1, OpBne, 0,   3'd0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 6);
        add(1, OpBne, 0,   3'd1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 6);
        add(1, OpBne, 0,   3'd2, 1, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 2'b01, 0, 6);
        // SLL
        add(1, OpSll, 0,   3'd0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 7);
        add(1, OpSll, 0,   3'd1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 7);
        add(1, OpSll, 0,   3'd2, 0, 0, 1, 0, 3'b100, 0, 1, 0, 0, 0, 0, 2'b00, 0, 7);
        add(1, OpSll, 0,   3'd4, 1, 0, 0, 0, 3'b000, 0, 1, 1, 0, 0, 0, 2'b00, 0, 7);
        // ORI
        add(1, OpOri, 0,   3'd0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 8);
        add(1, OpOri, 0,   3'd1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 8);
        add(1, OpOri, 0,   3'd2, 0, 0, 0, 1, 3'b011, 0, 0, 0, 0, 0, 0, 2'b00, 0, 8);
        add(1, OpOri, 0,   3'd4, 1, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 2'b00, 0, 8);

        // Reset values
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_irwre", 32'(IRWre), 32'd1);
        chk("reset_ctl", 32'(actCtl), 32'(19'b000_0100_0000_0000_0000));
        chk("reset_retired", 32'(retired), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            setIn(vecs[i].en, vecs[i].op, vecs[i].zero);
            chk($sformatf("vec%0d_ctl", i), 32'(actCtl), 32'(vecs[i].ctl));
            chk($sformatf("vec%0d_retired", i), 32'(retired), 32'(vecs[i].ret));
            @(negedge clk);
        end

        // ADD with en held low for three cycles in WB
        setIn(1, OpAdd, 0);
        chk("hold_if_state", 32'(state), 32'd0);
        chk("hold_if_retired", 32'(retired), 32'd9);
        @(negedge clk);
        setIn(1, OpAdd, 0);
        @(negedge clk);
        setIn(1, OpAdd, 0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            setIn(0, OpAdd, 0);
            chk($sformatf("hold%0d_state", k), 32'(state), 32'd4);
            chk($sformatf("hold%0d_regwre", k), 32'(RegWre), 32'd0);
            chk($sformatf("hold%0d_pcwre", k), 32'(PCWre), 32'd0);
            chk($sformatf("hold%0d_regdst", k), 32'(RegDst), 32'd1);
            chk($sformatf("hold%0d_retired", k), 32'(retired), 32'd9);
            @(negedge clk);
        end
        setIn(1, OpAdd, 0);
        chk("release_state", 32'(state), 32'd4);
        chk("release_regwre", 32'(RegWre), 32'd1);
        chk("release_pcwre", 32'(PCWre), 32'd1);
        @(negedge clk);

        // Unknown opcode acts as a two-cycle NOP
        setIn(1, OpNop, 0);
        chk("nop_if_state", 32'(state), 32'd0);
        chk("hold_done_retired", 32'(retired), 32'd10);
        @(negedge clk);
        setIn(1, OpNop, 0);
        chk("nop_id_state", 32'(state), 32'd1);
        chk("nop_id_pcwre", 32'(PCWre), 32'd1);
        chk("nop_id_pcsrc", 32'(PCSrc), 32'd0);
        @(negedge clk);

        // J
        setIn(1, OpJ, 0);
        chk("j_if_state", 32'(state), 32'd0);
        chk("nop_retired", 32'(retired), 32'd11);
        @(negedge clk);
        setIn(1, OpJ, 0);
        chk("j_id_state", 32'(state), 32'd1);
        chk("j_id_pcsrc", 32'(PCSrc), 32'd2);
        chk("j_id_pcwre", 32'(PCWre), 32'd1);
        @(negedge clk);

        // HALT
        setIn(1, OpHalt, 0);
        chk("halt_if_state", 32'(state), 32'd0);
        chk("j_retired", 32'(retired), 32'd12);
        @(negedge clk);
        setIn(1, OpHalt, 0);
        chk("halt_id_state", 32'(state), 32'd1);
        chk("halt_id_pcwre", 32'(PCWre), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            setIn(1, OpAdd, 0);
            chk($sformatf("halt%0d_state", k), 32'(state), 32'd7);
            chk($sformatf("halt%0d_halted", k), 32'(halted), 32'd1);
            chk($sformatf("halt%0d_pcwre", k), 32'(PCWre), 32'd0);
            chk($sformatf("halt%0d_retired", k), 32'(retired), 32'd12);
            @(negedge clk);
        end

        // Reset out of HALT, run one ADD, then reset during the next ADD's EXE
        rst_n = 1'b0;
        #1;
        chk("halt_reset_state", 32'(state), 32'd0);
        chk("halt_reset_halted", 32'(halted), 32'd0);
        chk("halt_reset_retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            setIn(1, OpAdd, 0);
            @(negedge clk);
        end
        setIn(1, OpAdd, 0);
        chk("post_reset_retired", 32'(retired), 32'd1);
        @(negedge clk);
        setIn(1, OpAdd, 0);
        @(negedge clk);
        setIn(1, OpAdd, 0);
        chk("midexe_state", 32'(state), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_retired", 32'(retired), 32'd0);
        chk("midrst_regwre", 32'(RegWre), 32'd0);
        chk("midrst_pcwre", 32'(PCWre), 32'd0);
        chk("midrst_irwre", 32'(IRWre), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
